// File: rtl/ocm_responder.sv
// On-chip memory responder: serves fixed-length read/write bursts from a RAM
// window mapped at BASE. Out-of-window writes are dropped and out-of-window reads return zero.
module ocm_responder #(
  parameter int              AN         = 24,
  parameter int              DN         = 16,
  parameter int              IDN        = 2,
  parameter int              BURST      = 8,
  parameter int              DEPTH_LOG2 = 10,
  parameter logic [AN-1:0]   BASE       = 24'hf00000
) (
  input  logic           clkSYS,
  input  logic           reset,
  input  logic           req,
  input  logic           wr,
  input  logic [AN-1:0]  addr,
  input  logic [DN-1:0]  data,
  input  logic [IDN-1:0] id,
  output logic           ack,
  output logic [DN-1:0]  mem_data,
  output logic [IDN-1:0] mem_id,
  output logic           valid
);

  localparam int BL    = $clog2(BURST);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The window test uses one extra bit so a window at the very top of the
  // address space does not wrap.
  localparam logic [AN:0] WIN_LO = {1'b0, BASE};
  localparam logic [AN:0] WIN_HI = WIN_LO + (AN+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RLAT,
    READ
  } state_t;

  state_t                  state, state_nxt;
  logic [BL-1:0]           beat, beat_nxt;
  logic [DEPTH_LOG2-BL-1:0] blk_q;
  logic                    win_q;
  logic [IDN-1:0]          id_q;

  logic                    addr_in_win;
  logic                    accept;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  logic [DN-1:0]           ram [DEPTH];
  logic [DN-1:0]           rd_q;

  // BASE is aligned to the RAM depth, so the window offset is simply the
  // low address bits.
  assign addr_in_win = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  assign accept      = (state == IDLE) && req && !reset;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    ack       = 1'b0;
    ram_we    = 1'b0;
    wr_idx    = {blk_q, beat};
    rd_idx    = {blk_q, beat};

    unique case (state)
      IDLE: begin
        if (req) begin
          ack    = 1'b1;
          wr_idx = {addr[DEPTH_LOG2-1:BL], BL'(0)};
          if (wr) begin
            ram_we    = addr_in_win;
            beat_nxt  = BL'(1);
            state_nxt = WRITE;
          end else begin
            beat_nxt  = '0;
            state_nxt = RLAT;
          end
        end
      end
      WRITE: begin
        if (req) begin
          ack      = 1'b1;
          ram_we   = win_q;
          beat_nxt = beat + BL'(1);
          if (beat == BL'(BURST-1)) state_nxt = IDLE;
        end
      end
      RLAT: begin
        beat_nxt  = beat + BL'(1);
        state_nxt = READ;
      end
      READ: begin
        // beat runs one word ahead of the output; it wraps to zero while the
        // last word is on the bus.
        if (beat == '0) state_nxt = IDLE;
        else            beat_nxt  = beat + BL'(1);
      end
      default: state_nxt = IDLE;
    endcase

    if (reset) begin
      ack       = 1'b0;
      ram_we    = 1'b0;
      state_nxt = IDLE;
      beat_nxt  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clkSYS) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
      blk_q <= '0;
      win_q <= 1'b0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (accept) begin
        blk_q <= addr[DEPTH_LOG2-1:BL];
        win_q <= addr_in_win;
        id_q  <= id;
      end
    end
  end

  // NOTE: the RAM array and its output register have no reset, which keeps
  // them mappable to block RAM and preserves contents across reset.
  always_ff @(posedge clkSYS) begin
    if (ram_we) ram[wr_idx] <= data;
    rd_q <= ram[rd_idx];
  end

  assign valid    = (state == READ);
  assign mem_id   = valid ? id_q : '0;
  assign mem_data = (valid && win_q) ? rd_q : '0;

endmodule

// File: doc/ocm_responder.md
OCM_RESPONDER -- requirements
Module: ocm_responder

Interface
REQ-001 Parameter AN, default 24: request address width, in 16-bit words.
REQ-002 Parameter DN, default 16: data width.
REQ-003 Parameter IDN, default 2: client id width.
REQ-004 Parameter BURST, default 8: words per transfer, power of two.
REQ-005 Parameter DEPTH_LOG2, default 10: log2 of on-chip RAM depth in words.
REQ-006 Parameter BASE, default 24'hf00000: first address of the window, aligned to 2^DEPTH_LOG2.
REQ-007 clkSYS  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 req  input  1  client request, held until accepted.
REQ-010 wr  input  1  1 = write burst, 0 = read burst; qualified by req.
REQ-011 addr  input  AN  burst start address; low log2(BURST) bits are ignored and treated as 0.
REQ-012 data  input  DN  write word; client advances to the next word after each ack.
REQ-013 id  input  IDN  client tag for read return.
REQ-014 ack  output  1  accept strobe; one per write word, one per read burst.
REQ-015 mem_data  output  DN  read return word.
REQ-016 mem_id  output  IDN  tag of the current return word.
REQ-017 valid  output  1  mem_data and mem_id are valid this cycle.

Function
REQ-018 The block SHALL implement the states IDLE, WRITE, RLAT and READ.
REQ-019 IDLE & req: ack SHALL be 1 combinationally; the block SHALL latch addr, id and wr.
REQ-020 IDLE & req & wr: the block SHALL store word 0 that cycle and go to WRITE with beat count 1.
REQ-021 IDLE & req & !wr: the block SHALL go to RLAT.
REQ-022 WRITE: ack SHALL equal req; each acked cycle SHALL store data at start+beat and increment the beat count.
REQ-023 WRITE with req=0: the block SHALL stall with no write and no ack; the beat count SHALL hold.
REQ-024 WRITE: after beat BURST-1 is stored, the block SHALL return to IDLE.
REQ-025 Read latency: the first valid SHALL come exactly 2 cycles after the ack cycle (1 cycle RLAT, 1 cycle registered RAM output).
REQ-026 READ: valid SHALL stay 1 for exactly BURST consecutive cycles, returning words start+0 .. start+BURST-1 in order, with mem_id = latched id.
REQ-027 READ: ack SHALL be 0 throughout; a new request SHALL be accepted no earlier than the cycle after the last valid.
REQ-028 RAM index SHALL be (address - BASE) mod 2^DEPTH_LOG2; address increments inside a burst SHALL wrap modulo BURST.
REQ-029 Out-of-window address (below BASE, or at/above BASE + 2^DEPTH_LOG2):
  - writes SHALL be acked normally with no RAM change;
  - reads SHALL return BURST words of zero with normal valid timing.
REQ-030 When valid=0, mem_data SHALL be 0 and mem_id SHALL be 0.
REQ-031 wr, addr, data and id SHALL be ignored whenever ack=0.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL:
  - go to IDLE and clear the beat counter;
  - drive ack=0, valid=0, mem_data=0, mem_id=0 on the following cycle.
REQ-033 Reset mid-burst SHALL abort the burst; words already written SHALL keep their values; RAM contents SHALL NOT be cleared.
REQ-034 While reset=1, ack SHALL be 0 even if req=1.

Verification
REQ-035 Write burst, BASE+0x10, data 0x1000..0x1007, req held -> 8 consecutive acks; read BASE+0x10 id=2 -> valid 2 cycles after ack, 8 beats 0x1000..0x1007, mem_id=2.
REQ-036 Write burst with req dropped for 3 cycles after beat 3 -> ack low for those 3 cycles; readback still 0x1000..0x1007 in order.
REQ-037 Read at addr BASE+0x13 -> returns the words at 0x10..0x17 (low bits ignored).
REQ-038 Write 0xFFFF to BASE+0x400 (DEPTH_LOG2=10) -> 8 acks, no RAM change; read of the same address -> 8 zero words; read of BASE+0 -> unchanged data.
REQ-039 Assert reset at the 4th beat of a read -> next cycle valid=0, mem_data=0, state IDLE; a following read of the same address returns the full correct burst.
REQ-040 Issue a read, then hold req during READ -> ack=0 until the cycle after the 8th valid, then ack=1.
